// File: rtl/core_exec_stage.sv
// ----------------------------------------------------------------------------
// core_exec_stage
//
// Execute-stage pipeline register wrapped around the core ALU. Operands come
// from decode/register-read, RAW hazards are resolved by forwarding from the
// stage's own result register and from the writeback port. The ALU result,
// destination info and an undefined-op marker are registered and offered to
// writeback over a valid/ready handshake. Architectural NZCV flags live here.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   flush                   kill the held result and any same-cycle transfer
//   in_valid / in_ready     decode-side handshake
//   in_op                   ALU op: 0 ADD, 1 SUB, 2 AND, 3 EOR, 4 ORR (5..7 undefined)
//   in_ra_idx, in_rb_idx    source register indices
//   in_ra_val, in_rb_val    register-file read values
//   in_use_imm, in_imm      operand B select / immediate (already extended)
//   in_rd, in_wb_en         destination index / destination write enable
//   in_set_flags            instruction updates NZCV
//   wb_en, wb_rd, wb_q      value being written back this cycle
//   out_valid / out_ready   writeback-side handshake
//   out_q                   registered ALU result
//   out_rd, out_wb_en       registered destination info
//   out_undef               registered undefined-op marker
//   flags                   architectural NZCV {N,Z,C,V}
// ----------------------------------------------------------------------------
module core_exec_stage #(
    parameter int W  = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [RW-1:0] in_ra_idx,
    input  logic [RW-1:0] in_rb_idx,
    input  logic [W-1:0]  in_ra_val,
    input  logic [W-1:0]  in_rb_val,
    input  logic          in_use_imm,
    input  logic [W-1:0]  in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic          in_wb_en,
    input  logic          in_set_flags,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [W-1:0]  wb_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_q,
    output logic [RW-1:0] out_rd,
    output logic          out_wb_en,
    output logic          out_undef,
    output logic [3:0]    flags
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_EOR = 3'd3;
    localparam logic [2:0] OP_ORR = 3'd4;

    // Result register state
    logic                 vld_p1;
    logic signed [W-1:0]  q_p1;
    logic [RW-1:0]        rd_p1;
    logic                 wb_en_p1;
    logic                 undef_p1;
    logic [3:0]           nzcv_p1;

    // Execute-stage combinational signals
    logic                 take;
    logic signed [W-1:0]  opa;
    logic signed [W-1:0]  opb;
    logic signed [W-1:0]  res;
    logic [W:0]           sum_x;
    logic [W:0]           dif_x;
    logic                 undef;
    logic [3:0]           nzcv_next;

    // Three-way operand source: the instruction currently in the result
    // register is youngest, then the one being written back, then the RF.
    function automatic logic [W-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [W-1:0]  rf_val,
        input logic          e_hit_ok,
        input logic [RW-1:0] e_rd,
        input logic [W-1:0]  e_q,
        input logic          w_en,
        input logic [RW-1:0] w_rd,
        input logic [W-1:0]  w_q
    );
        if (e_hit_ok && (e_rd == idx))
            return e_q;
        else if (w_en && (w_rd == idx))
            return w_q;
        else
            return rf_val;
    endfunction

    // Signed overflow for addition: operands agree in sign, result does not.
    function automatic logic add_ovf(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic signed [W-1:0] s
    );
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Signed overflow for subtraction: operands differ in sign and the
    // result's sign differs from the minuend.
    function automatic logic sub_ovf(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic signed [W-1:0] d
    );
        return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endfunction

    assign in_ready = !vld_p1 || out_ready;
    assign take     = in_valid && in_ready;

    always_comb begin
        opa = fwd_sel(in_ra_idx, in_ra_val, vld_p1 && wb_en_p1, rd_p1, q_p1,
                      wb_en, wb_rd, wb_q);
        if (in_use_imm)
            opb = in_imm;
        else
            opb = fwd_sel(in_rb_idx, in_rb_val, vld_p1 && wb_en_p1, rd_p1, q_p1,
                          wb_en, wb_rd, wb_q);
    end

    always_comb begin
        sum_x     = {1'b0, opa} + {1'b0, opb};
        dif_x     = {1'b0, opa} - {1'b0, opb};
        res       = '0;
        undef     = 1'b0;
        // C and V default to their architectural values so logic ops keep them.
        nzcv_next = nzcv_p1;
        case (in_op)
            OP_ADD: begin
                res          = sum_x[W-1:0];
                nzcv_next[1] = sum_x[W];
                nzcv_next[0] = add_ovf(opa, opb, sum_x[W-1:0]);
            end
            OP_SUB: begin
                res          = dif_x[W-1:0];
                // Top bit of the extended difference is the borrow.
                nzcv_next[1] = !dif_x[W];
                nzcv_next[0] = sub_ovf(opa, opb, dif_x[W-1:0]);
            end
            OP_AND:  res = opa & opb;
            OP_EOR:  res = opa ^ opb;
            OP_ORR:  res = opa | opb;
            default: undef = 1'b1;
        endcase
        nzcv_next[3] = res[W-1];
        nzcv_next[2] = (res == '0);
    end

    // ---- stage boundary: execute -> result register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            q_p1     <= '0;
            rd_p1    <= '0;
            wb_en_p1 <= 1'b0;
            undef_p1 <= 1'b0;
            nzcv_p1  <= 4'b0000;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (take) begin
            vld_p1   <= 1'b1;
            q_p1     <= res;
            rd_p1    <= in_rd;
            wb_en_p1 <= in_wb_en;
            undef_p1 <= undef;
            if (in_set_flags && !undef)
                nzcv_p1 <= nzcv_next;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_q     = q_p1;
    assign out_rd    = rd_p1;
    assign out_wb_en = wb_en_p1;
    assign out_undef = undef_p1;
    assign flags     = nzcv_p1;

endmodule

// File: doc/core_exec_stage.md
# core_exec_stage

Execute-stage pipeline register wrapped around the core ALU. It takes decoded operands from the decode/register-read stage and resolves RAW hazards by forwarding. It evaluates the operation, computes NZCV flags, and presents a registered result to the writeback stage over a valid/ready handshake. Flush support lets the front end kill the in-flight result on a branch redirect.

## Interface
- W, 16, datapath width (matches ALU width)
- RW, 4, register index width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- flush  in  1  kill accepted/held instruction
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_op  in  alu_op  ADD/SUB/AND/EOR/ORR encoding
- in_ra_idx, in_rb_idx  in  RW  source register indices
- in_ra_val, in_rb_val  in  W  register-file read values
- in_use_imm  in  1  operand B = in_imm instead of rb
- in_imm  in  W  immediate, already extended
- in_rd  in  RW  destination index
- in_wb_en  in  1  instruction writes rd
- in_set_flags  in  1  instruction updates NZCV
- wb_en, wb_rd, wb_q  in  1/RW/W  value being written back this cycle (forwarding source 2)
- out_valid  out  1  result register holds a live instruction
- out_ready  in  1  writeback consumes
- out_q  out  W  registered ALU result
- out_rd, out_wb_en  out  RW/1  registered destination info
- out_undef  out  1  registered: op was not one of the five defined codes
- flags  out  4  architectural NZCV {N,Z,C,V}

## Operation
- Handshake: in_ready = !out_valid || out_ready. Transfer on in_valid && in_ready. Output held stable while out_valid && !out_ready.
- Operand A priority: (out_valid && out_wb_en && out_rd==in_ra_idx) -> out_q; else (wb_en && wb_rd==in_ra_idx) -> wb_q; else in_ra_val.
- Operand B: in_use_imm -> in_imm; otherwise the same three-way priority applied to in_rb_idx.
- Result: q from ALU on forwarded operands. Undefined op -> q = 0, out_undef = 1.
- Flags, computed at W+1 bits:
  - N = q[W-1]; Z = (q == 0).
  - ADD: C = carry out; V = signed overflow (a,b same sign, q differs).
  - SUB: C = no-borrow (a >= b unsigned); V = a,b differ in sign and q sign differs from a.
  - AND/EOR/ORR: C and V unchanged.
  - Committed to flags only on transfer with in_set_flags && !flush && op defined.
- Flush: out_valid cleared next edge. Any same-cycle input transfer is dropped, and its flags are not committed. flush overrides out_ready.

## Timing
- Latency 1: instruction accepted at edge k appears on out_* after edge k; out_valid high in cycle k+1.
- Throughput 1/cycle while out_ready held high; back-to-back dependent ops forward with no bubble.
- Stall: out_ready low with out_valid high -> in_ready low, all out_* and flags frozen.
- Reset (rst_n low at edge): out_valid=0, out_q=0, out_rd=0, out_wb_en=0, out_undef=0, flags=4'b0000. in_ready is therefore 1 the cycle after reset.
- Reset mid-stall discards the held result; nothing is replayed.
- Simultaneous out_ready and in_valid with out_valid=1: old result retires and new one loads in the same edge.
- Forwarding uses only the current out_* register and wb_* port; there is no deeper history.

## Test plan
- Reset then ADD 0x7FFF+0x0001 with set_flags -> out_q=0x8000, flags=N1 Z0 C0 V1 one cycle later.
- SUB r1=0x0005 - r2=0x0005 -> out_q=0x0000, flags=N0 Z1 C1 V0; then an AND with set_flags keeps C1 V0 and updates N/Z.
- ADD r3=r1+r2 (result 0x0010) then EOR r4=r3^imm 0x00FF back-to-back with stale in_ra_val=0 -> second out_q=0x00EF, no bubble; the same dependency via wb_* only -> wb_q used.
- Hold out_ready=0 for 3 cycles with a result held -> in_ready=0, out_q/flags stable; release -> old retires and next instruction loads on the same edge.
- Assert flush with out_valid=1 and in_valid=1 (set_flags) -> out_valid=0 next cycle, flags unchanged, no result emitted.
- Drive an undefined op encoding -> out_q=0x0000, out_undef=1, flags unchanged even with set_flags=1.
